riscv_load_store_unit: RTL and testbench

RISCV_LOAD_STORE_UNIT -- requirements
Module: riscv_load_store_unit

---
 rtl/riscv_defines.sv | 22 ++
 rtl/riscv_lsu_align.sv | 47 ++++
 rtl/riscv_load_store_unit.sv | 144 ++++++++++++++
 tb/tb_riscv_load_store_unit.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared definitions for the load/store unit: FSM states, access-size codes
// and the alignment rule used to reject accesses the bus cannot express.
package riscv_defines;

    typedef enum logic [1:0] {
        IDLE                 = 2'd0,
        WAIT_RVALID          = 2'd1,
        WAIT_RVALID_EX_STALL = 2'd2,
        IDLE_EX_STALL        = 2'd3
    } lsu_state_e;

    localparam logic [1:0] TYPE_WORD = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;
    localparam logic [1:0] TYPE_BYTE = 2'b10;

    // Both 2'b10 and 2'b11 encode a byte access, so only word/half can misalign.
    function automatic logic is_misaligned(input logic [1:0] dtype, input logic [1:0] lsb);
        return ((dtype == TYPE_WORD) && (lsb != 2'b00)) ||
               ((dtype == TYPE_HALF) && (lsb == 2'b11));
    endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: store enables/rotation on the request side and
// load rotation plus zero/sign extension on the response side.
module riscv_lsu_align
    import riscv_defines::*;
(
    input  logic [1:0]  i_type,
    input  logic [1:0]  i_addr_lsb,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [1:0]  i_rtype,
    input  logic [1:0]  i_rlsb,
    input  logic        i_rsign,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_wShift;
    logic [4:0]  w_rShift;
    logic [31:0] w_rdataRot;

    assign w_wShift = {i_addr_lsb, 3'b000};
    assign w_rShift = {i_rlsb, 3'b000};

    // A shift by 32 yields zero, which makes the zero-offset rotate fall out naturally.
    assign o_wdata    = (i_wdata << w_wShift) | (i_wdata >> (6'd32 - {1'b0, w_wShift}));
    assign w_rdataRot = (i_rdata >> w_rShift) | (i_rdata << (6'd32 - {1'b0, w_rShift}));

    always_comb begin
        o_be = 4'b0000;
        case (i_type)
            TYPE_WORD: o_be = 4'b1111;
            TYPE_HALF: o_be = 4'b0011 << i_addr_lsb;
            default:   o_be = 4'b0001 << i_addr_lsb;
        endcase
    end

    always_comb begin
        o_rdata = w_rdataRot;
        case (i_rtype)
            TYPE_WORD: o_rdata = w_rdataRot;
            TYPE_HALF: o_rdata = {{16{i_rsign & w_rdataRot[15]}}, w_rdataRot[15:0]};
            default:   o_rdata = {{24{i_rsign & w_rdataRot[7]}}, w_rdataRot[7:0]};
        endcase
    end

endmodule

// File: rtl/riscv_load_store_unit.sv
// Load/store unit: issues one data-bus transaction at a time, tracks whether
// the EX stage has handed the instruction on, and returns aligned load data.
module riscv_load_store_unit
    import riscv_defines::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_ex_i,
    input  logic        data_we_ex_i,
    input  logic [1:0]  data_type_ex_i,
    input  logic        data_sign_ext_ex_i,
    input  logic [31:0] operand_a_ex_i,
    input  logic [31:0] operand_b_ex_i,
    input  logic [31:0] data_wdata_ex_i,
    input  logic        ex_valid_i,
    output logic [31:0] data_rdata_ex_o,
    output logic        lsu_ready_ex_o,
    output logic        lsu_ready_wb_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic        data_misaligned_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic        busy_o
);

    lsu_state_e  r_state;
    logic        r_we;
    logic [1:0]  r_type;
    logic        r_signExt;
    logic [1:0]  r_addrLsb;
    logic [31:0] r_rdata;

    logic [31:0] w_addr;
    logic        w_misaligned;
    logic        w_stall;
    logic        w_waiting;
    logic        w_rvalidOk;
    logic        w_issueWindow;
    logic        w_grant;
    logic        w_accepted;
    logic [31:0] w_rdataExt;

    assign w_addr        = operand_a_ex_i + operand_b_ex_i;
    assign w_misaligned  = is_misaligned(data_type_ex_i, w_addr[1:0]);
    assign w_stall       = (r_state == WAIT_RVALID_EX_STALL) || (r_state == IDLE_EX_STALL);
    assign w_waiting     = (r_state == WAIT_RVALID) || (r_state == WAIT_RVALID_EX_STALL);
    assign w_rvalidOk    = data_rvalid_i & w_waiting;

    // A new request may only go out when nothing is outstanding or the outstanding one retires now.
    assign w_issueWindow = rst_n & ((r_state == IDLE) | ((r_state == WAIT_RVALID) & data_rvalid_i));
    assign data_req_o    = w_issueWindow & data_req_ex_i & ~w_misaligned;
    assign w_grant       = data_req_o & data_gnt_i;
    assign w_accepted    = ~data_req_ex_i | data_gnt_i | w_misaligned;

    assign data_addr_o       = {w_addr[31:2], 2'b00};
    assign data_we_o         = data_we_ex_i;
    assign data_misaligned_o = rst_n & ~w_stall & data_req_ex_i & w_misaligned;
    assign load_err_o        = w_rvalidOk & data_err_i & ~r_we;
    assign store_err_o       = w_rvalidOk & data_err_i & r_we;
    assign busy_o            = (r_state != IDLE) | data_req_o;
    assign lsu_ready_wb_o    = (r_state == WAIT_RVALID) ? data_rvalid_i : 1'b1;
    assign data_rdata_ex_o   = w_rvalidOk ? w_rdataExt : r_rdata;

    always_comb begin
        lsu_ready_ex_o = 1'b1;
        if (rst_n) begin
            case (r_state)
                IDLE:        lsu_ready_ex_o = w_accepted;
                WAIT_RVALID: lsu_ready_ex_o = data_rvalid_i & w_accepted;
                default:     lsu_ready_ex_o = 1'b1;
            endcase
        end
    end

    riscv_lsu_align u_align (
        .i_type     (data_type_ex_i),
        .i_addr_lsb (w_addr[1:0]),
        .i_wdata    (data_wdata_ex_i),
        .o_be       (data_be_o),
        .o_wdata    (data_wdata_o),
        .i_rtype    (r_type),
        .i_rlsb     (r_addrLsb),
        .i_rsign    (r_signExt),
        .i_rdata    (data_rdata_i),
        .o_rdata    (w_rdataExt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_type    <= TYPE_WORD;
            r_signExt <= 1'b0;
            r_addrLsb <= 2'b00;
            r_rdata   <= 32'h0;
        end else begin
            if (w_grant) begin
                r_we      <= data_we_ex_i;
                r_type    <= data_type_ex_i;
                r_signExt <= data_sign_ext_ex_i;
                r_addrLsb <= w_addr[1:0];
            end
            if (w_rvalidOk && !r_we) begin
                r_rdata <= w_rdataExt;
            end
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state <= ex_valid_i ? WAIT_RVALID : WAIT_RVALID_EX_STALL;
                    end
                end
                WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        if (w_grant) begin
                            r_state <= ex_valid_i ? WAIT_RVALID : WAIT_RVALID_EX_STALL;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                WAIT_RVALID_EX_STALL: begin
                    if (data_rvalid_i) begin
                        r_state <= ex_valid_i ? IDLE : IDLE_EX_STALL;
                    end
                end
                IDLE_EX_STALL: begin
                    if (ex_valid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_load_store_unit.sv
// Directed bench for riscv_load_store_unit: a transaction-level model is
// compared every cycle, and literal expectations pin the key scenarios.
module tb_riscv_load_store_unit;
    import riscv_defines::*;

    logic        clk;
    logic        rst_n;
    logic        data_req_ex_i;
    logic        data_we_ex_i;
    logic [1:0]  data_type_ex_i;
    logic        data_sign_ext_ex_i;
    logic [31:0] operand_a_ex_i;
    logic [31:0] operand_b_ex_i;
    logic [31:0] data_wdata_ex_i;
    logic        ex_valid_i;
    logic [31:0] data_rdata_ex_o;
    logic        lsu_ready_ex_o;
    logic        lsu_ready_wb_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;
    logic        data_misaligned_o;
    logic        load_err_o;
    logic        store_err_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [1:0]  typ;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wdata;
        logic        exValid;
        logic        gnt;
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } stim_t;

    riscv_load_store_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .data_req_ex_i      (data_req_ex_i),
        .data_we_ex_i       (data_we_ex_i),
        .data_type_ex_i     (data_type_ex_i),
        .data_sign_ext_ex_i (data_sign_ext_ex_i),
        .operand_a_ex_i     (operand_a_ex_i),
        .operand_b_ex_i     (operand_b_ex_i),
        .data_wdata_ex_i    (data_wdata_ex_i),
        .ex_valid_i         (ex_valid_i),
        .data_rdata_ex_o    (data_rdata_ex_o),
        .lsu_ready_ex_o     (lsu_ready_ex_o),
        .lsu_ready_wb_o     (lsu_ready_wb_o),
        .data_req_o         (data_req_o),
        .data_gnt_i         (data_gnt_i),
        .data_rvalid_i      (data_rvalid_i),
        .data_err_i         (data_err_i),
        .data_addr_o        (data_addr_o),
        .data_we_o          (data_we_o),
        .data_be_o          (data_be_o),
        .data_wdata_o       (data_wdata_o),
        .data_rdata_i       (data_rdata_i),
        .data_misaligned_o  (data_misaligned_o),
        .load_err_o         (load_err_o),
        .store_err_o        (store_err_o),
        .busy_o             (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: one outstanding access at most, plus whether
    // the issuing instruction still owes its hand-over to WB.
    logic        mOut;
    logic        mOwed;
    logic        mWe;
    logic [1:0]  mType;
    logic        mSign;
    logic [1:0]  mLsb;
    logic [31:0] mLast;

    function automatic logic [31:0] modelAddr();
        return operand_a_ex_i + operand_b_ex_i;
    endfunction

    function automatic logic modelMis();
        logic [31:0] ad;
        ad = modelAddr();
        if (data_type_ex_i == 2'b00) return (ad % 4) != 0;
        if (data_type_ex_i == 2'b01) return (ad % 4) == 3;
        return 1'b0;
    endfunction

    function automatic logic modelReq();
        logic canIssue;
        canIssue = !mOwed && (!mOut || data_rvalid_i);
        return data_req_ex_i && !modelMis() && canIssue;
    endfunction

    function automatic logic [3:0] modelBe();
        int n;
        int lsb;
        logic [3:0] be;
        lsb = int'(modelAddr() % 4);
        n = (data_type_ex_i == 2'b00) ? 4 : (data_type_ex_i == 2'b01) ? 2 : 1;
        if (n == 4) return 4'b1111;
        be = 4'b0000;
        for (int i = 0; i < 4; i++) be[i] = (i >= lsb) && (i < lsb + n);
        return be;
    endfunction

    function automatic logic [31:0] modelWdata();
        int lsb;
        logic [31:0] w;
        lsb = int'(modelAddr() % 4);
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = data_wdata_ex_i[8*((i - lsb + 4) % 4) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] t, input logic s,
                                              input logic [1:0] lsbIn, input logic [31:0] d);
        logic [7:0]  lane [4];
        logic [15:0] h;
        int lsb;
        lsb = int'(lsbIn);
        for (int i = 0; i < 4; i++) lane[i] = d[8*i +: 8];
        if (t == 2'b00)
            return {lane[(lsb+3)%4], lane[(lsb+2)%4], lane[(lsb+1)%4], lane[lsb]};
        if (t == 2'b01) begin
            h = {lane[(lsb+1)%4], lane[lsb]};
            return (s && h[15]) ? {16'hFFFF, h} : {16'h0000, h};
        end
        return (s && lane[lsb][7]) ? {24'hFFFFFF, lane[lsb]} : {24'h000000, lane[lsb]};
    endfunction

    always @(posedge clk or negedge rst_n) begin : modelUpdate
        logic respNow;
        logic grantNow;
        if (!rst_n) begin
            mOut  = 1'b0;
            mOwed = 1'b0;
            mWe   = 1'b0;
            mType = 2'b00;
            mSign = 1'b0;
            mLsb  = 2'b00;
            mLast = 32'h0;
        end else begin
            respNow  = mOut && data_rvalid_i;
            grantNow = modelReq() && data_gnt_i;
            if (respNow) begin
                if (!mWe) mLast = modelLoad(mType, mSign, mLsb, data_rdata_i);
                mOut = 1'b0;
                if (mOwed) mOwed = !ex_valid_i;
            end else if (!mOut && mOwed && ex_valid_i) begin
                mOwed = 1'b0;
            end
            if (grantNow) begin
                mOut  = 1'b1;
                mOwed = !ex_valid_i;
                mWe   = data_we_ex_i;
                mType = data_type_ex_i;
                mSign = data_sign_ext_ex_i;
                mLsb  = modelAddr() % 4;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle out of reset, all outputs are compared against the model.
    always @(negedge clk) begin : compareProc
        logic respNow;
        logic expReq;
        logic expMis;
        logic expRdyEx;
        logic expRdyWb;
        if (rst_n) begin
            respNow = mOut && data_rvalid_i;
            expReq  = modelReq();
            expMis  = data_req_ex_i && modelMis() && !mOwed;
            if (mOwed) expRdyEx = 1'b1;
            else if (mOut && !data_rvalid_i) expRdyEx = 1'b0;
            else expRdyEx = !data_req_ex_i || data_gnt_i || modelMis();
            expRdyWb = (mOut && !mOwed) ? data_rvalid_i : 1'b1;
            checkOutput("m_req",      32'(data_req_o), 32'(expReq));
            checkOutput("m_addr",     data_addr_o, modelAddr() & 32'hFFFF_FFFC);
            checkOutput("m_we",       32'(data_we_o), 32'(data_we_ex_i));
            checkOutput("m_be",       32'(data_be_o), 32'(modelBe()));
            checkOutput("m_wdata",    data_wdata_o, modelWdata());
            checkOutput("m_mis",      32'(data_misaligned_o), 32'(expMis));
            checkOutput("m_rdyEx",    32'(lsu_ready_ex_o), 32'(expRdyEx));
            checkOutput("m_rdyWb",    32'(lsu_ready_wb_o), 32'(expRdyWb));
            checkOutput("m_rdata",    data_rdata_ex_o,
                        respNow ? modelLoad(mType, mSign, mLsb, data_rdata_i) : mLast);
            checkOutput("m_loadErr",  32'(load_err_o), 32'(respNow && data_err_i && !mWe));
            checkOutput("m_storeErr", 32'(store_err_o), 32'(respNow && data_err_i && mWe));
            checkOutput("m_busy",     32'(busy_o), 32'(mOut || mOwed || expReq));
        end
    end

    function automatic stim_t base();
        stim_t s;
        s = '0;
        s.exValid = 1'b1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        data_req_ex_i      = s.req;
        data_we_ex_i       = s.we;
        data_type_ex_i     = s.typ;
        data_sign_ext_ex_i = s.sign;
        operand_a_ex_i     = s.a;
        operand_b_ex_i     = s.b;
        data_wdata_ex_i    = s.wdata;
        ex_valid_i         = s.exValid;
        data_gnt_i         = s.gnt;
        data_rvalid_i      = s.rvalid;
        data_err_i         = s.err;
        data_rdata_i       = s.rdata;
    endtask

    // Drive one cycle's inputs just after the rising edge; return at the falling edge.
    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        drive(s);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : mainSeq
        stim_t s;
        rst_n = 1'b0;
        s = base();
        s.req = 1'b1; s.gnt = 1'b1; s.rvalid = 1'b1; s.err = 1'b1; s.rdata = 32'hA5A5A5A5;
        drive(s);
        #12;
        checkOutput("rst_req",      32'(data_req_o), 32'd0);
        checkOutput("rst_rdyEx",    32'(lsu_ready_ex_o), 32'd1);
        checkOutput("rst_rdyWb",    32'(lsu_ready_wb_o), 32'd1);
        checkOutput("rst_mis",      32'(data_misaligned_o), 32'd0);
        checkOutput("rst_loadErr",  32'(load_err_o), 32'd0);
        checkOutput("rst_storeErr", 32'(store_err_o), 32'd0);
        checkOutput("rst_busy",     32'(busy_o), 32'd0);
        checkOutput("rst_rdata",    data_rdata_ex_o, 32'd0);
        drive(base());
        #10;
        rst_n = 1'b1;

        $display("[TB] signed byte load at 0x1003");
        s = base(); s.req = 1'b1; s.typ = 2'b10; s.sign = 1'b1; s.a = 32'h1000; s.b = 32'h3; s.gnt = 1'b1;
        applyStimulus(s);
        checkOutput("b_be",    32'(data_be_o), 32'h8);
        checkOutput("b_addr",  data_addr_o, 32'h1000);
        checkOutput("b_req",   32'(data_req_o), 32'd1);
        checkOutput("b_rdyEx", 32'(lsu_ready_ex_o), 32'd1);
        s = base(); s.rvalid = 1'b1; s.rdata = 32'h8000_0000;
        applyStimulus(s);
        checkOutput("b_state", 32'(dut.r_state), 32'(WAIT_RVALID));
        checkOutput("b_rdata", data_rdata_ex_o, 32'hFFFF_FF80);
        checkOutput("b_rdyWb", 32'(lsu_ready_wb_o), 32'd1);
        applyStimulus(base());
        checkOutput("b_hold",  data_rdata_ex_o, 32'hFFFF_FF80);
        checkOutput("b_busy",  32'(busy_o), 32'd0);

        $display("[TB] half store at 0x2002 with delayed grant");
        s = base(); s.req = 1'b1; s.we = 1'b1; s.typ = 2'b01; s.a = 32'h2000; s.b = 32'h2;
        s.wdata = 32'h0000_BEEF;
        applyStimulus(s);
        checkOutput("h_be",    32'(data_be_o), 32'hC);
        checkOutput("h_wdata", data_wdata_o, 32'hBEEF_0000);
        checkOutput("h_addr",  data_addr_o, 32'h2000);
        checkOutput("h_rdyEx", 32'(lsu_ready_ex_o), 32'd0);
        checkOutput("h_busy",  32'(busy_o), 32'd1);
        s.gnt = 1'b1;
        applyStimulus(s);
        checkOutput("h_req",   32'(data_req_o), 32'd1);
        checkOutput("h_rdyEx2", 32'(lsu_ready_ex_o), 32'd1);
        s = base(); s.rvalid = 1'b1;
        applyStimulus(s);
        checkOutput("h_storeErr", 32'(store_err_o), 32'd0);
        applyStimulus(base());
        checkOutput("h_hold",  data_rdata_ex_o, 32'hFFFF_FF80);

        $display("[TB] misaligned word load at 0x3001");
        s = base(); s.req = 1'b1; s.a = 32'h3000; s.b = 32'h1;
        applyStimulus(s);
        checkOutput("m1_mis",   32'(data_misaligned_o), 32'd1);
        checkOutput("m1_req",   32'(data_req_o), 32'd0);
        checkOutput("m1_rdyEx", 32'(lsu_ready_ex_o), 32'd1);
        s.gnt = 1'b1;
        applyStimulus(s);
        checkOutput("m2_req",   32'(data_req_o), 32'd0);
        checkOutput("m2_mis",   32'(data_misaligned_o), 32'd1);
        applyStimulus(base());
        checkOutput("m3_state", 32'(dut.r_state), 32'(IDLE));

        $display("[TB] grant while EX stalled, late rvalid");
        s = base(); s.req = 1'b1; s.a = 32'h4000; s.b = 32'h4; s.gnt = 1'b1; s.exValid = 1'b0;
        applyStimulus(s);
        checkOutput("s0_req", 32'(data_req_o), 32'd1);
        s = base(); s.exValid = 1'b0; s.req = 1'b1; s.gnt = 1'b1;
        applyStimulus(s);
        checkOutput("s1_state", 32'(dut.r_state), 32'(WAIT_RVALID_EX_STALL));
        checkOutput("s1_req",   32'(data_req_o), 32'd0);
        s = base(); s.exValid = 1'b0;
        applyStimulus(s);
        s.rvalid = 1'b1; s.rdata = 32'h1234_5678;
        applyStimulus(s);
        checkOutput("s3_rdata", data_rdata_ex_o, 32'h1234_5678);
        s = base(); s.exValid = 1'b0; s.req = 1'b1; s.gnt = 1'b1;
        applyStimulus(s);
        checkOutput("s4_state", 32'(dut.r_state), 32'(IDLE_EX_STALL));
        checkOutput("s4_req",   32'(data_req_o), 32'd0);
        applyStimulus(base());
        checkOutput("s5_state", 32'(dut.r_state), 32'(IDLE_EX_STALL));
        applyStimulus(base());
        checkOutput("s6_state", 32'(dut.r_state), 32'(IDLE));
        checkOutput("s6_rdata", data_rdata_ex_o, 32'h1234_5678);

        $display("[TB] back-to-back loads");
        s = base(); s.req = 1'b1; s.typ = 2'b01; s.a = 32'h5000; s.b = 32'h2; s.gnt = 1'b1;
        applyStimulus(s);
        applyStimulus(base());
        checkOutput("bb_rdyEx", 32'(lsu_ready_ex_o), 32'd0);
        checkOutput("bb_rdyWb", 32'(lsu_ready_wb_o), 32'd0);
        s = base(); s.rvalid = 1'b1; s.rdata = 32'hABCD_0000;
        s.req = 1'b1; s.typ = 2'b10; s.sign = 1'b1; s.a = 32'h5000; s.b = 32'h1; s.gnt = 1'b1;
        applyStimulus(s);
        checkOutput("bb_rdata1", data_rdata_ex_o, 32'h0000_ABCD);
        checkOutput("bb_req2",   32'(data_req_o), 32'd1);
        checkOutput("bb_be2",    32'(data_be_o), 32'h2);
        s = base(); s.rvalid = 1'b1; s.rdata = 32'h0000_FF00;
        applyStimulus(s);
        checkOutput("bb_state",  32'(dut.r_state), 32'(WAIT_RVALID));
        checkOutput("bb_rdata2", data_rdata_ex_o, 32'hFFFF_FFFF);
        applyStimulus(base());
        checkOutput("bb_idle",   32'(dut.r_state), 32'(IDLE));

        $display("[TB] store with bus error, then a clean load");
        s = base(); s.req = 1'b1; s.we = 1'b1; s.a = 32'h6000; s.wdata = 32'hCAFE_F00D; s.gnt = 1'b1;
        applyStimulus(s);
        checkOutput("e_wdata", data_wdata_o, 32'hCAFE_F00D);
        s = base(); s.rvalid = 1'b1; s.err = 1'b1;
        applyStimulus(s);
        checkOutput("e_storeErr", 32'(store_err_o), 32'd1);
        checkOutput("e_loadErr",  32'(load_err_o), 32'd0);
        s = base(); s.req = 1'b1; s.a = 32'h6000; s.b = 32'h8; s.gnt = 1'b1;
        applyStimulus(s);
        checkOutput("e_storeErr2", 32'(store_err_o), 32'd0);
        checkOutput("e_addr",      data_addr_o, 32'h6008);
        s = base(); s.rvalid = 1'b1; s.rdata = 32'h1122_3344;
        applyStimulus(s);
        checkOutput("e_rdata", data_rdata_ex_o, 32'h1122_3344);

        $display("[TB] stray rvalid in IDLE");
        s = base(); s.rvalid = 1'b1; s.err = 1'b1; s.rdata = 32'hDEAD_BEEF;
        applyStimulus(s);
        checkOutput("x_rdata",   data_rdata_ex_o, 32'h1122_3344);
        checkOutput("x_loadErr", 32'(load_err_o), 32'd0);

        $display("[TB] reset during an outstanding load");
        s = base(); s.req = 1'b1; s.a = 32'h7000; s.gnt = 1'b1;
        applyStimulus(s);
        @(posedge clk);
        #2;
        drive(base());
        rst_n = 1'b0;
        #2;
        checkOutput("r_state", 32'(dut.r_state), 32'(IDLE));
        checkOutput("r_rdata", data_rdata_ex_o, 32'd0);
        checkOutput("r_busy",  32'(busy_o), 32'd0);
        #3;
        rst_n = 1'b1;
        s = base(); s.rvalid = 1'b1; s.err = 1'b1; s.rdata = 32'h5555_5555;
        applyStimulus(s);
        checkOutput("r_stray",   data_rdata_ex_o, 32'd0);
        checkOutput("r_loadErr", 32'(load_err_o), 32'd0);
        s = base(); s.req = 1'b1; s.typ = 2'b11; s.a = 32'h8000; s.b = 32'h2; s.gnt = 1'b1;
        applyStimulus(s);
        checkOutput("r_be", 32'(data_be_o), 32'h4);
        s = base(); s.rvalid = 1'b1; s.rdata = 32'h00F0_0000;
        applyStimulus(s);
        checkOutput("r_byte", data_rdata_ex_o, 32'h0000_00F0);
        applyStimulus(base());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
